pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake on both sides. Operands split into STAGES equal chunks; one chunk resolved per pipeline stage, carry registered between stages. Successor to the single-cycle ripple adder in the arithmetic library. Sits between operand sources and ALU result muxing wherever long carry chains break timing.

Parameters:
N, 32, operand/result width in bits; must be divisible by STAGES
STAGES, 4, pipeline depth = number of chunks; 1 <= STAGES <= N
CW, N/STAGES, derived chunk width; not overridable

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept beat this cycle
a  input  N  operand A
b  input  N  operand B
mode  input  1  0 = add, 1 = subtract
cin  input  1  carry-in (add) / borrow-in (sub)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  N  result
cout  output  1  raw carry-out of MSB
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits 0, out_valid 0, sum/cout/ovf 0; in-flight beats discarded. Reset mid-operation drops all data; first accept after reset at earliest in the cycle after rst deasserts.
- Arithmetic: B' = mode ? ~b : b; C0 = mode ? ~cin : cin. Result = a + B' + C0 mod 2^N. Add: a+b+cin. Sub: a-b-cin.
- cout = carry from bit N-1 (sub: 1 means no borrow). ovf = (a[N-1] == B'[N-1]) && (sum[N-1] != a[N-1]).
- Stage k (0..STAGES-1) adds chunk k of a and B' with the carry registered from stage k-1 (stage 0 uses C0), writes sum chunk k; higher chunks of a/B' and lower sum chunks travel down the pipe as registered payload.
- Accept when in_valid && in_ready. Latency: exactly STAGES cycles accept-to-out_valid with no backpressure. Throughput 1 beat/cycle.
- Backpressure: stage k holds when full and stage k+1 cannot take. Stage k may load when empty or stage k+1 advancing. in_ready = stage-0 loadable; combinationally depends on out_ready (ready chain, no skid buffer). Output stage register drives sum/cout/ovf/out_valid.
- Output held stable while out_valid && !out_ready. No beat lost or duplicated. Order preserved.
- Pipeline full with out_ready=0: in_ready=0. Simultaneous pop and push when full: both occur, occupancy unchanged.
- STAGES=1: single registered adder, latency 1.
- Inputs other than in_valid are don't-care when in_valid=0.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined: on ovf, sum replaced by signed saturation (0x7FF..F if a[N-1]=0, 0x800..0 if a[N-1]=1); ovf, cout still report raw values. Applied in final stage, no latency change.
- Not defined: sum always wraps modulo 2^N.

Decomposition:
- Shared package arith_pkg: mode encoding constants (ARITH_ADD=0, ARITH_SUB=1); saturation constant functions of N.
- One sub-module: addsub_pipe_stage (CW-bit chunk adder with carry in/out, valid/ready and payload registers), instantiated STAGES times in a generate loop.

Test Plan:
- N=32, STAGES=4, add a=0x0000_FFFF, b=0x0000_0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0001_0000, cout=0, ovf=0 (carry crosses chunk boundary).
- Sub a=0x8000_0000, b=1, cin=0 -> sum=0x7FFF_FFFF, cout=1, ovf=1; with ADDSUB_SAT_EN sum=0x8000_0000.
- Add a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
- Stream 10 back-to-back random beats, out_ready toggled 1,0,0,1,... -> all 10 results correct, in order, sum stable while stalled; in_ready=0 after 4 beats queued with out_ready=0.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0, sum=0 next cycle; no stale beat emerges afterwards.
- STAGES=1, N=8: add 0x7F+0x01 -> sum=0x80, ovf=1, latency 1 cycle.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: mode encodings and
// saturation constants for signed N-bit results.
package arith_pkg;

    localparam logic ARITH_ADD = 1'b0;
    localparam logic ARITH_SUB = 1'b1;

    // Wide enough for any practical datapath; callers truncate to N.
    localparam int SAT_MAXW = 1024;

    function automatic logic [SAT_MAXW-1:0] sat_max(input int n);
        logic [SAT_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < n - 1; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [SAT_MAXW-1:0] sat_min(input int n);
        logic [SAT_MAXW-1:0] r;
        r = '0;
        r[n-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/addsub_pipe_stage.sv
// One CW-bit chunk of the pipelined adder plus its payload registers.
// The last stage computes ovf and, with ADDSUB_SAT_EN, saturates sum.
module addsub_pipe_stage
    import arith_pkg::*;
#(
    parameter int N    = 32,
    parameter int CW   = 8,
    parameter int K    = 0,
    parameter bit LAST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] bp,
    input  logic [N-1:0] sum,
    input  logic         carry,
    input  logic         ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a_q,
    output logic [N-1:0] bp_q,
    output logic [N-1:0] sum_q,
    output logic         carry_q,
    output logic         ovf_q
);

`ifdef ADDSUB_SAT_EN
    localparam logic [N-1:0] SAT_MAX = N'(sat_max(N));
    localparam logic [N-1:0] SAT_MIN = N'(sat_min(N));
`endif

    logic [CW:0]  chunk;
    logic [N-1:0] sum_d;
    logic         ovf_d;

    always_comb begin
        chunk = {1'b0, a[K*CW +: CW]}
              + {1'b0, bp[K*CW +: CW]}
              + {{CW{1'b0}}, carry};
        sum_d = sum;
        sum_d[K*CW +: CW] = chunk[CW-1:0];
        ovf_d = ovf;
        if (LAST) begin
            ovf_d = (a[N-1] == bp[N-1])
                 && (sum_d[N-1] != a[N-1]);
`ifdef ADDSUB_SAT_EN
            if (ovf_d) begin
                sum_d = a[N-1] ? SAT_MIN : SAT_MAX;
            end
`endif
        end
    end

    // Loadable when empty or when the downstream stage drains us.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_q       <= '0;
            bp_q      <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                a_q     <= a;
                bp_q    <= bp;
                sum_q   <= sum_d;
                carry_q <= chunk[CW];
                ovf_q   <= ovf_d;
            end
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit add/sub, one CW-bit chunk per stage, valid/ready both sides.
// Optional signed saturation of sum when ADDSUB_SAT_EN is defined.
module pipelined_addsub
    import arith_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = N / STAGES;

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [STAGES:0] cy;
    logic [STAGES:0] ov;
    logic [N-1:0]    av [STAGES+1];
    logic [N-1:0]    bv [STAGES+1];
    logic [N-1:0]    sv [STAGES+1];
    logic            sub;
    logic            unused_tail;

    assign sub = (mode == ARITH_SUB);

    assign vld[0]  = in_valid;
    assign in_ready = rdy[0];
    assign av[0]   = a;
    assign bv[0]   = sub ? ~b : b;
    assign sv[0]   = '0;
    assign cy[0]   = sub ? ~cin : cin;
    assign ov[0]   = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_pipe_stage #(
            .N    (N),
            .CW   (CW),
            .K    (k),
            .LAST (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .a         (av[k]),
            .bp        (bv[k]),
            .sum       (sv[k]),
            .carry     (cy[k]),
            .ovf       (ov[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .a_q       (av[k+1]),
            .bp_q      (bv[k+1]),
            .sum_q     (sv[k+1]),
            .carry_q   (cy[k+1]),
            .ovf_q     (ov[k+1])
        );
    end

    // Final stage register drives the result port directly.
    assign rdy[STAGES] = out_ready;
    assign out_valid   = vld[STAGES];
    assign sum         = sv[STAGES];
    assign cout        = cy[STAGES];
    assign ovf         = ov[STAGES];

    assign unused_tail = ^{av[STAGES], bv[STAGES]};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (N=32/STAGES=4 and N=8/STAGES=1).
module tb_pipelined_addsub;

    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    localparam logic [N-1:0] DA [3] = '{32'h0000_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    localparam logic [N-1:0] DB [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    localparam logic         DM [3] = '{1'b0, 1'b1, 1'b0};
    localparam logic         DC [3] = '{1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    localparam logic [N-1:0] DS [3] = '{32'h0001_0000, 32'h8000_0000, 32'h0000_0000};
    localparam logic [7:0]   S8 = 8'h7F;
`else
    localparam logic [N-1:0] DS [3] = '{32'h0001_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    localparam logic [7:0]   S8 = 8'h80;
`endif
    localparam logic         DCO [3] = '{1'b0, 1'b1, 1'b1};
    localparam logic         DOV [3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, mode, cin;
    logic         out_valid, out_ready, cout, ovf;
    logic [N-1:0] a, b, sum;

    pipelined_addsub #(.N(N), .STAGES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    logic       rst8, iv8, ir8, m8, c8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, s8;

    pipelined_addsub #(.N(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst8),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .mode(m8), .cin(c8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .ovf(of8)
    );

    res_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic fire_in, fire_out;
    res_t got;

    function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic m, input logic c);
        logic [N-1:0] yp;
        logic [N:0]   t;
        res_t         r;
        yp = m ? ~y : y;
        t = {1'b0, x} + {1'b0, yp} + {{N{1'b0}}, (m ? ~c : c)};
        r.sum  = t[N-1:0];
        r.cout = t[N];
        r.ovf  = (x[N-1] == yp[N-1]) && (r.sum[N-1] != x[N-1]);
`ifdef ADDSUB_SAT_EN
        if (r.ovf) r.sum = x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        return r;
    endfunction

    // Samples handshakes mid-cycle, records accepted beats, advances one clock.
    task automatic tick();
        @(negedge clk);
        fire_in  = in_valid && in_ready && !rst;
        fire_out = out_valid && out_ready && !rst;
        got      = '{sum, cout, ovf};
        if (fire_in) sb.push_back(model(a, b, mode, cin));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        a    = $urandom;
        b    = $urandom;
        mode = 1'($urandom_range(0, 1));
        cin  = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = 1'b0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests++;
        if (sum !== '0) begin
            fails++; $display("FAIL reset_sum got %h want 0", sum);
        end
        tests++;
        if ({cout, ovf} !== 2'b00) begin
            fails++; $display("FAIL reset_flags got %b%b want 00", cout, ovf);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        sb.delete();
    endtask

    task automatic test_directed();
        for (int i = 0; i < 3; i++) begin
            int cyc;
            a = DA[i]; b = DB[i]; mode = DM[i]; cin = DC[i];
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            tests++;
            if (cyc !== 4) begin
                fails++; $display("FAIL latency[%0d] got %0d want 4", i, cyc);
            end
            tests++;
            if ({sum, cout, ovf} !== {DS[i], DCO[i], DOV[i]}) begin
                fails++;
                $display("FAIL directed[%0d] got %h/%b/%b want %h/%b/%b",
                         i, sum, cout, ovf, DS[i], DCO[i], DOV[i]);
            end
            tick();
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic stall;
        logic [N-1:0] held;
        res_t exp;
        while ((sent < 10 || recv < 10) && cyc < 300) begin
            in_valid  = (sent < 10);
            rand_beat();
            out_ready = (cyc % 3 == 0);
            stall = out_valid && !out_ready;
            held  = sum;
            tick();
            cyc++;
            if (fire_in) sent++;
            if (stall) begin
                tests++;
                if (!out_valid || sum !== held) begin
                    fails++;
                    $display("FAIL stall_hold got %b/%h want 1/%h", out_valid, sum, held);
                end
            end
            if (fire_out) begin
                recv++;
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL b2b_extra got %h want none", got.sum);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL b2b[%0d] got %h want %h", recv, got, exp);
                    end
                end
            end
        end
        tests++;
        if (recv !== 10) begin
            fails++; $display("FAIL b2b_count got %0d want 10", recv);
        end
    endtask

    task automatic test_full();
        int acc = 0;
        int cyc = 0;
        res_t exp;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            tick();
            if (fire_in) acc++;
        end
        tests++;
        if (acc !== 4) begin
            fails++; $display("FAIL full_accepts got %0d want 4", acc);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL full_in_ready got %b want 0", in_ready);
        end
        out_ready = 1'b1;
        rand_beat();
        tick();
        tests++;
        if (!(fire_in && fire_out)) begin
            fails++; $display("FAIL push_pop got %b%b want 11", fire_in, fire_out);
        end
        in_valid = 1'b0;
        while (cyc < 50 && (fire_out || sb.size() > 0)) begin
            if (fire_out) begin
                tests++;
                exp = sb.pop_front();
                if (got !== exp) begin
                    fails++; $display("FAIL full_drain got %h want %h", got, exp);
                end
            end
            if (sb.size() == 0) break;
            tick();
            cyc++;
        end
        tests++;
        if (sb.size() !== 0) begin
            fails++; $display("FAIL full_left got %0d want 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            fails++; $display("FAIL midreset got %b/%h want 0/0", out_valid, sum);
        end
        sb.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL stale_beats got %0d want 0", seen);
        end
    endtask

    task automatic test_stages1();
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        a8 = 8'h7F; b8 = 8'h01; m8 = 1'b0; c8 = 1'b0;
        iv8 = 1'b1; or8 = 1'b1;
        tests++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            fails++; $display("FAIL s1_idle got %b%b want 10", ir8, ov8);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        tests++;
        if (ov8 !== 1'b1) begin
            fails++; $display("FAIL s1_latency got %b want 1", ov8);
        end
        tests++;
        if ({s8, co8, of8} !== {S8, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL s1_result got %h/%b/%b want %h/0/1", s8, co8, of8, S8);
        end
        @(posedge clk); #1;
        tests++;
        if (ov8 !== 1'b0) begin
            fails++; $display("FAIL s1_drain got %b want 0", ov8);
        end
    endtask

    initial begin
        rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0;
        a8 = '0; b8 = '0; m8 = 1'b0; c8 = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_full();
        test_reset_midflight();
        test_stages1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
